// File: rtl/temp_qsys_oci_trace_pkg.sv
// Shared widths, frame type codes, trace code values and packer state encoding for the OCI DCT packer.
// Frame builders keep the DCT/ADDR bit layout in a single place.
package temp_qsys_oci_trace_pkg;

  localparam int CODE_W = 2;
  localparam int BUF_W  = 30;
  localparam int CNT_W  = 4;
  localparam int PC_W   = 32;
  localparam int FRM_W  = 36;

  localparam logic [1:0] FT_DCT  = 2'b00;
  localparam logic [1:0] FT_ADDR = 2'b01;

  localparam logic [CODE_W-1:0] TC_ILLEGAL   = 2'b00;
  localparam logic [CODE_W-1:0] TC_NOT_TAKEN = 2'b01;
  localparam logic [CODE_W-1:0] TC_TAKEN     = 2'b10;
  localparam logic [CODE_W-1:0] TC_SEQ       = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_FLUSH,
    ST_ADDR
  } pack_state_t;

  function automatic logic [FRM_W-1:0] dct_frame(input logic [CNT_W-1:0] cnt,
                                                 input logic [BUF_W-1:0] codes);
    return {FT_DCT, cnt, codes};
  endfunction

  function automatic logic [FRM_W-1:0] addr_frame(input logic [PC_W-1:0] pc);
    return {FT_ADDR, 2'b00, pc};
  endfunction

endpackage

// File: rtl/temp_qsys_nios2_gen2_cpu_oci_frame_reg.sv
// Single-entry valid/ready output register for trace frames.
// free is high when a new frame may be loaded this cycle (empty, or draining on this edge).
module temp_qsys_nios2_gen2_cpu_oci_frame_reg
  import temp_qsys_oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [FRM_W-1:0] load_data,
  input  logic             frm_ready,
  output logic             frm_valid,
  output logic [FRM_W-1:0] frm_data,
  output logic             free
);

  logic             valid_reg;
  logic [FRM_W-1:0] data_reg;

  assign free      = !valid_reg || frm_ready;
  assign frm_valid = valid_reg;
  assign frm_data  = data_reg;

  // Data only changes on load, so it stays stable while the FIFO back-pressures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (frm_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/temp_qsys_nios2_gen2_cpu_oci_dct_packer.sv
// Packs 2-bit direct-branch trace codes into a 30-bit accumulator and emits DCT/ADDR frames.
// Optional feature: define OCI_DCT_DROP_CNT_EN to add the saturating drop_cnt output.
module temp_qsys_nios2_gen2_cpu_oci_dct_packer
  import temp_qsys_oci_trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              inst_valid,
  input  logic [CODE_W-1:0] inst_code,
  input  logic              ind_valid,
  input  logic [PC_W-1:0]   ind_pc,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [FRM_W-1:0]  frm_data,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef OCI_DCT_DROP_CNT_EN
  ,output logic [7:0]       drop_cnt
`endif
);

  pack_state_t      state_reg, state_next;
  logic [BUF_W-1:0] buf_reg, buf_next, buf_s;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_s;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic             pc_pend_reg, pc_pend_next;
  logic             trc_d_reg;
  logic             ovf_reg;

  logic             trc_fall, ind_evt, code_evt, accept;
  logic             drop_code, drop_pc;
  logic             load, free;
  logic [FRM_W-1:0] load_data;
  pack_state_t      resume_state;

  assign dct_buffer = buf_reg;
  assign dct_count  = cnt_reg;
  assign ovf        = ovf_reg;

  assign trc_fall = trc_d_reg && !trc_on;
  assign ind_evt  = trc_on && ind_valid;
  assign code_evt = trc_on && inst_valid && (inst_code != TC_ILLEGAL);
  // A waiting flush freezes the accumulator; a full accumulator cannot take more.
  assign accept    = code_evt && (cnt_reg != CNT_FULL) && (state_reg != ST_FLUSH);
  assign drop_code = code_evt && !accept;

  // Post-shift view: a code arriving with a flush trigger lands in the flushed frame.
  assign buf_s = accept ? {buf_reg[BUF_W-CODE_W-1:0], inst_code} : buf_reg;
  assign cnt_s = accept ? cnt_reg + 4'd1 : cnt_reg;

  assign resume_state = trc_on ? ST_PACK : ST_IDLE;

  always_comb begin
    state_next   = state_reg;
    buf_next     = buf_s;
    cnt_next     = cnt_s;
    pc_next      = pc_reg;
    pc_pend_next = pc_pend_reg;
    load         = 1'b0;
    load_data    = dct_frame(cnt_s, buf_s);
    drop_pc      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_PACK: begin
        state_next = resume_state;
        if (ind_evt) begin
          pc_pend_next = 1'b1;
          pc_next      = ind_pc;
        end
        if ((cnt_s == CNT_FULL) || ind_evt || trc_fall) begin
          if (cnt_s == '0) begin
            if (ind_evt) state_next = ST_ADDR;
          end else if (free) begin
            load       = 1'b1;
            buf_next   = '0;
            cnt_next   = '0;
            state_next = ind_evt ? ST_ADDR : resume_state;
          end else begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (ind_evt) begin
          if (pc_pend_reg) begin
            drop_pc = 1'b1;
          end else begin
            pc_pend_next = 1'b1;
            pc_next      = ind_pc;
          end
        end
        if (free) begin
          load       = 1'b1;
          buf_next   = '0;
          cnt_next   = '0;
          state_next = pc_pend_next ? ST_ADDR : resume_state;
        end
      end
      ST_ADDR: begin
        drop_pc = ind_evt;
        if (free) begin
          load         = 1'b1;
          load_data    = addr_frame(pc_reg);
          pc_pend_next = 1'b0;
          // Codes packed behind the address frame still owe a flush if full or trace stopped.
          if ((cnt_s == CNT_FULL) || (!trc_on && (cnt_s != '0)))
            state_next = ST_FLUSH;
          else
            state_next = resume_state;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      buf_reg     <= '0;
      cnt_reg     <= '0;
      pc_reg      <= '0;
      pc_pend_reg <= 1'b0;
      trc_d_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      buf_reg     <= buf_next;
      cnt_reg     <= cnt_next;
      pc_reg      <= pc_next;
      pc_pend_reg <= pc_pend_next;
      trc_d_reg   <= trc_on;
      if (drop_code || drop_pc)
        ovf_reg <= 1'b1;
      else if (ovf_clr)
        ovf_reg <= 1'b0;
    end
  end

`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  logic [8:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_reg} + {7'd0, {1'b0, drop_code} + {1'b0, drop_pc}};
  assign drop_cnt = drop_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt_reg <= '0;
    else if (drop_code || drop_pc)
      drop_cnt_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    else if (ovf_clr)
      drop_cnt_reg <= '0;
  end
`endif

  temp_qsys_nios2_gen2_cpu_oci_frame_reg u_frame_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .frm_ready (frm_ready),
    .frm_valid (frm_valid),
    .frm_data  (frm_data),
    .free      (free)
  );

endmodule

// File: tb/tb_temp_qsys_nios2_gen2_cpu_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: one task per scenario, hand-computed expected frames.
// Build with OCI_DCT_DROP_CNT_EN defined to also exercise drop_cnt.
module tb_temp_qsys_nios2_gen2_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trc_on = 1'b0;
  logic        inst_valid = 1'b0;
  logic [1:0]  inst_code = 2'b00;
  logic        ind_valid = 1'b0;
  logic [31:0] ind_pc = '0;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [35:0] frm_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        ovf;
  logic        ovf_clr = 1'b0;
`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  temp_qsys_nios2_gen2_cpu_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .inst_valid (inst_valid),
    .inst_code  (inst_code),
    .ind_valid  (ind_valid),
    .ind_pc     (ind_pc),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .frm_data   (frm_data),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef OCI_DCT_DROP_CNT_EN
    ,.drop_cnt  (drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if ({frm_valid, dct_count, ovf} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: valid/count/ovf got %b expected 000000", {frm_valid, dct_count, ovf});
    end
    vectors++;
    if ({frm_data, dct_buffer} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_data: data=%h buf=%h expected 0", frm_data, dct_buffer);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    $display("reset released: valid=%b count=%0d ovf=%b", frm_valid, dct_count, ovf);
  endtask

  task automatic test_full();
    trc_on = 1'b1;
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      inst_valid = 1'b1;
      inst_code = 2'b10;
      tick();
      if (i == 2) begin
        vectors++;
        if ({dct_count, dct_buffer[5:0]} !== {4'd3, 6'b101010}) begin
          miscompares++;
          $display("FAIL full_shift: count=%0d buf=%h expected 3 / 2a", dct_count, dct_buffer);
        end
      end
      if (i == 13) begin
        vectors++;
        if ({frm_valid, dct_count} !== {1'b0, 4'd14}) begin
          miscompares++;
          $display("FAIL full_14: valid=%b count=%0d expected 0 / 14", frm_valid, dct_count);
        end
      end
    end
    inst_valid = 1'b0;
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'hF, 30'h2AAAAAAA}) begin
      miscompares++;
      $display("FAIL full_frame: valid=%b data=%h expected 1 / %h", frm_valid, frm_data,
               {2'b00, 4'hF, 30'h2AAAAAAA});
    end
    vectors++;
    if ({dct_count, dct_buffer} !== 34'h0) begin
      miscompares++;
      $display("FAIL full_clear: count=%0d buf=%h expected 0", dct_count, dct_buffer);
    end
    tick();
    vectors++;
    if (frm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain: valid=%b expected 0", frm_valid);
    end
    $display("full: 15 taken codes -> one DCT frame");
  endtask

  task automatic test_ind();
    logic [1:0] codes [3];
    codes[0] = 2'b01; codes[1] = 2'b10; codes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      inst_valid = 1'b1;
      inst_code = codes[i];
      tick();
    end
    inst_valid = 1'b0;
    vectors++;
    if ({dct_count, dct_buffer} !== {4'd3, 30'h1B}) begin
      miscompares++;
      $display("FAIL ind_acc: count=%0d buf=%h expected 3 / 1b", dct_count, dct_buffer);
    end
    ind_valid = 1'b1;
    ind_pc = 32'h0000_1000;
    tick();
    ind_valid = 1'b0;
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'd3, 30'h1B} || dct_count !== 4'd0) begin
      miscompares++;
      $display("FAIL ind_dct: valid=%b data=%h count=%0d expected 1 / %h / 0", frm_valid,
               frm_data, dct_count, {2'b00, 4'd3, 30'h1B});
    end
    tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== 36'h4_0000_1000) begin
      miscompares++;
      $display("FAIL ind_addr: valid=%b data=%h expected 1 / 400001000", frm_valid, frm_data);
    end
    tick();
    vectors++;
    if (frm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ind_drain: valid=%b expected 0", frm_valid);
    end
    $display("ind: partial DCT flushed, then ADDR frame");
  endtask

  task automatic test_ind_only();
    ind_valid = 1'b1;
    ind_pc = 32'hDEAD_BEEC;
    tick();
    ind_valid = 1'b0;
    for (int i = 0; i < 4 && frm_valid !== 1'b1; i++) tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== 36'h4_DEAD_BEEC) begin
      miscompares++;
      $display("FAIL ind_only_first: valid=%b data=%h expected 1 / 4deadbeec", frm_valid, frm_data);
    end
    tick();
    vectors++;
    if (frm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ind_only_extra: valid=%b data=%h expected no further frame", frm_valid, frm_data);
    end
    $display("ind_only: empty accumulator -> ADDR frame only");
  endtask

  task automatic test_trc_off();
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1;
      inst_code = 2'b11;
      tick();
    end
    vectors++;
    if ({dct_count, dct_buffer} !== {4'd5, 30'h3FF}) begin
      miscompares++;
      $display("FAIL trc_acc: count=%0d buf=%h expected 5 / 3ff", dct_count, dct_buffer);
    end
    trc_on = 1'b0;
    tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'd5, 30'h3FF} || dct_count !== 4'd0) begin
      miscompares++;
      $display("FAIL trc_flush: valid=%b data=%h count=%0d expected 1 / %h / 0", frm_valid,
               frm_data, dct_count, {2'b00, 4'd5, 30'h3FF});
    end
    tick();
    vectors++;
    if ({frm_valid, dct_count} !== 5'b0) begin
      miscompares++;
      $display("FAIL trc_ignored: valid=%b count=%0d expected 0 / 0", frm_valid, dct_count);
    end
    inst_valid = 1'b0;
    trc_on = 1'b1;
    tick();
    $display("trc_off: falling trace enable flushes count 5");
  endtask

  task automatic test_illegal();
    inst_valid = 1'b1;
    inst_code = 2'b00;
    tick();
    tick();
    vectors++;
    if ({frm_valid, dct_count} !== 5'b0) begin
      miscompares++;
      $display("FAIL illegal_empty: valid=%b count=%0d expected 0 / 0", frm_valid, dct_count);
    end
    inst_code = 2'b01;
    tick();
    inst_code = 2'b00;
    tick();
    vectors++;
    if ({frm_valid, dct_count, dct_buffer} !== {1'b0, 4'd1, 30'h1}) begin
      miscompares++;
      $display("FAIL illegal_hold: valid=%b count=%0d buf=%h expected 0 / 1 / 1", frm_valid,
               dct_count, dct_buffer);
    end
    inst_valid = 1'b0;
    trc_on = 1'b0;
    tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'd1, 30'h1}) begin
      miscompares++;
      $display("FAIL illegal_flush: valid=%b data=%h expected 1 / %h", frm_valid, frm_data,
               {2'b00, 4'd1, 30'h1});
    end
    trc_on = 1'b1;
    tick();
    $display("illegal: code 00 neither counted nor framed");
  endtask

  // First batch fills the free output register, the second refills the accumulator
  // behind the held frame, and only the third batch has nowhere to go.
  task automatic test_overflow();
    frm_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 15; i++) begin
        inst_valid = 1'b1;
        inst_code = (b == 0) ? 2'b10 : (b == 1) ? 2'b01 : 2'b11;
        tick();
      end
      vectors++;
      if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'hF, 30'h2AAAAAAA}) begin
        miscompares++;
        $display("FAIL ovf_hold_b%0d: valid=%b data=%h expected 1 / %h", b, frm_valid, frm_data,
                 {2'b00, 4'hF, 30'h2AAAAAAA});
      end
      if (b > 0) begin
        vectors++;
        if ({dct_count, dct_buffer} !== {4'hF, 30'h15555555} || ovf !== (b == 2)) begin
          miscompares++;
          $display("FAIL ovf_acc_b%0d: count=%0d buf=%h ovf=%b expected 15 / 15555555 / %0d", b,
                   dct_count, dct_buffer, ovf, (b == 2));
        end
      end
    end
`ifdef OCI_DCT_DROP_CNT_EN
    vectors++;
    if (drop_cnt !== 8'd15) begin
      miscompares++;
      $display("FAIL ovf_drop_cnt: got %0d expected 15", drop_cnt);
    end
`endif
    inst_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
    end
    inst_valid = 1'b1;
    inst_code = 2'b11;
    tick();
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: ovf=%b expected 1", ovf);
    end
`ifdef OCI_DCT_DROP_CNT_EN
    vectors++;
    if (drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL ovf_cnt_set_wins: got %0d expected 1", drop_cnt);
    end
`endif
    ovf_clr = 1'b0;
    inst_valid = 1'b0;
    frm_ready = 1'b1;
    tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== {2'b00, 4'hF, 30'h15555555} || dct_count !== 4'd0) begin
      miscompares++;
      $display("FAIL ovf_second: valid=%b data=%h count=%0d expected 1 / %h / 0", frm_valid,
               frm_data, dct_count, {2'b00, 4'hF, 30'h15555555});
    end
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("overflow: held frame stable, accumulator stuck at 15, drops flagged");
  endtask

  task automatic test_pc_drop();
    frm_ready = 1'b0;
    inst_valid = 1'b1;
    inst_code = 2'b10;
    tick();
    inst_valid = 1'b0;
    ind_valid = 1'b1;
    ind_pc = 32'h0000_A000;
    tick();
    inst_valid = 1'b1;
    inst_code = 2'b01;
    ind_pc = 32'h0000_B000;
    tick();
    inst_valid = 1'b0;
    ind_valid = 1'b0;
    vectors++;
    if (ovf !== 1'b1 || frm_data !== {2'b00, 4'd1, 30'h2} || dct_count !== 4'd1) begin
      miscompares++;
      $display("FAIL pc_drop: ovf=%b data=%h count=%0d expected 1 / %h / 1", ovf, frm_data,
               dct_count, {2'b00, 4'd1, 30'h2});
    end
    frm_ready = 1'b1;
    tick();
    vectors++;
    if (frm_valid !== 1'b1 || frm_data !== 36'h4_0000_A000) begin
      miscompares++;
      $display("FAIL pc_keep_first: valid=%b data=%h expected 1 / 40000a000", frm_valid, frm_data);
    end
    tick();
    trc_on = 1'b0;
    tick();
    trc_on = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("pc_drop: second pending pc dropped, first emitted");
  endtask

  task automatic test_async_reset();
    frm_ready = 1'b0;
    inst_valid = 1'b1;
    inst_code = 2'b11;
    tick();
    inst_valid = 1'b0;
    ind_valid = 1'b1;
    ind_pc = 32'h0000_C000;
    tick();
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    ind_valid = 1'b0;
    vectors++;
    if ({frm_valid, dct_count, ovf} !== {1'b1, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL arst_setup: valid/count/ovf=%b expected 100011", {frm_valid, dct_count, ovf});
    end
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({frm_valid, dct_count, ovf, dct_buffer, frm_data} !== 72'h0) begin
      miscompares++;
      $display("FAIL arst: valid=%b count=%0d ovf=%b buf=%h data=%h expected all 0", frm_valid,
               dct_count, ovf, dct_buffer, frm_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    $display("async_reset: pending frame and state discarded");
  endtask

  initial begin
    test_reset();
    test_full();
    test_ind();
    test_ind_only();
    test_trc_off();
    test_illegal();
    test_overflow();
    test_pc_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
